timer_ctrl: RTL and testbench

//   Sequencing controller for a W-bit up-counter: start/stop/pause, terminal count,
//   one-shot or periodic auto-reload, done pulse, sticky interrupt.

---
 rtl/timer_pkg.sv | 14 +
 rtl/timer_count_core.sv | 24 ++
 rtl/timer_ctrl.sv | 168 ++++++++++++++++
 tb/tb_timer_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the timer channel controller: FSM state encoding
// and the meaning of the mode input.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/timer_count_core.sv
// W-bit up-counter datapath for one timer channel. Clear has priority over
// enable; the count wraps modulo 2^W.
module timer_count_core #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  // Counter register: clear wins over increment, otherwise hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/timer_ctrl.sv
// Timer channel sequencing controller: start/stop/pause, terminal count,
// one-shot or periodic reload, done pulse and sticky interrupt.
// Optional feature macro: TIMER_CTRL_PRESCALE_EN adds the presc port and a
// prescaler so the counter advances every presc+1 clocks while running.
//
// Control inputs are plain levels, not a valid/ready handshake: start is
// honoured only in IDLE, stop aborts from any state, pause holds RUN in
// PAUSE for as long as it is high. Per-edge priority is
// stop > terminal count > pause > increment.
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int W    = 4,
  parameter int PS_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            stop,
  input  logic            pause,
  input  logic            mode,
  input  logic [W-1:0]    load_val,
  input  logic            irq_clr,
`ifdef TIMER_CTRL_PRESCALE_EN
  input  logic [PS_W-1:0] presc,
`endif
  output logic [W-1:0]    count,
  output logic            busy,
  output logic            done,
  output logic            irq,
  output logic [1:0]      dbg_state
);

  if (W < 2 || W > 32 || PS_W < 1) begin : g_bad_param
    $error("timer_ctrl: W must be 2..32 and PS_W at least 1");
  end

  state_t         state_q, state_d;
  logic [W-1:0]   tc_q;
  logic           mode_q;
  logic           cnt_clr, cnt_en;
  logic           done_d, latch_en;
  logic           psc_clr, psc_adv;
  logic           tick;

  timer_count_core #(.W(W)) u_core (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (count)
  );

`ifdef TIMER_CTRL_PRESCALE_EN
  logic [PS_W-1:0] psc_q;

  // Prescaler: cleared on start/stop/tick, advances on non-tick RUN cycles,
  // and simply holds while paused.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      psc_q <= '0;
    end else if (psc_clr) begin
      psc_q <= '0;
    end else if (psc_adv) begin
      psc_q <= psc_q + 1'b1;
    end
  end

  assign tick = (psc_q == presc);
`else
  logic unused_psc;
  assign unused_psc = psc_clr ^ psc_adv;
  assign tick       = 1'b1;
`endif

  // Run parameters are captured once at start so mid-run changes are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tc_q   <= '0;
      mode_q <= MODE_ONESHOT;
    end else if (latch_en) begin
      tc_q   <= load_val;
      mode_q <= mode;
    end
  end

  // State register plus done pulse and sticky irq (a new done beats irq_clr).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      done    <= 1'b0;
      irq     <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= done_d;
      if (done_d) begin
        irq <= 1'b1;
      end else if (irq_clr) begin
        irq <= 1'b0;
      end
    end
  end

  // Next-state and datapath controls.
  always_comb begin
    state_d  = state_q;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    done_d   = 1'b0;
    latch_en = 1'b0;
    psc_clr  = 1'b0;
    psc_adv  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (stop) begin
          cnt_clr = 1'b1;
          psc_clr = 1'b1;
        end else if (start) begin
          latch_en = 1'b1;
          cnt_clr  = 1'b1;
          psc_clr  = 1'b1;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop) begin
          cnt_clr = 1'b1;
          psc_clr = 1'b1;
          state_d = ST_IDLE;
        end else if (tick && (count == tc_q)) begin
          // Terminal count: pulse done, then reload or finish.
          done_d  = 1'b1;
          psc_clr = 1'b1;
          if (mode_q == MODE_PERIODIC) begin
            cnt_clr = 1'b1;
            state_d = pause ? ST_PAUSE : ST_RUN;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (pause) begin
          // Prescaler is left untouched so a pending tick fires on resume.
          state_d = ST_PAUSE;
        end else if (tick) begin
          cnt_en  = 1'b1;
          psc_clr = 1'b1;
        end else begin
          psc_adv = 1'b1;
        end
      end
      ST_PAUSE: begin
        if (stop) begin
          cnt_clr = 1'b1;
          psc_clr = 1'b1;
          state_d = ST_IDLE;
        end else if (!pause) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl (W=4). Inputs change 1 time unit after a
// rising edge and outputs are sampled at that same point.
module tb_timer_ctrl;
  import timer_pkg::*;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         start, stop, pause, mode, irq_clr;
  logic [W-1:0] load_val;
  logic [7:0]   presc;
  logic [W-1:0] count;
  logic         busy, done, irq;
  logic [1:0]   dbg_state;

  int vecs = 0;
  int errs = 0;

  // clock / reset
  always #5 clk = ~clk;

  timer_ctrl #(.W(W), .PS_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .pause     (pause),
    .mode      (mode),
    .load_val  (load_val),
    .irq_clr   (irq_clr),
`ifdef TIMER_CTRL_PRESCALE_EN
    .presc     (presc),
`endif
    .count     (count),
    .busy      (busy),
    .done      (done),
    .irq       (irq),
    .dbg_state (dbg_state)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // launch a run: start sampled at the next edge (E0)
  task automatic launch(input logic [W-1:0] tc, input logic md);
    load_val = tc;
    mode     = md;
    start    = 1'b1;
    step();
    start    = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    vecs++;
    if ({count, busy, done, irq, dbg_state} !== '0)
      begin errs++; $display("FAIL reset_state: got %h want 0", {count, busy, done, irq, dbg_state}); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_oneshot();
    launch(4'd3, MODE_ONESHOT);
    load_val = 4'd1;  // must be ignored mid-run
    vecs++;
    if ({count, busy, done} !== {4'd0, 1'b1, 1'b0})
      begin errs++; $display("FAIL oneshot_e0: got %h want %h", {count, busy, done}, {4'd0, 1'b1, 1'b0}); end
    for (int i = 1; i <= 3; i++) begin
      step();
      vecs++;
      if ({count, busy, done} !== {4'(i), 1'b1, 1'b0})
        begin errs++; $display("FAIL oneshot_e%0d: got %h want %h", i, {count, busy, done}, {4'(i), 1'b1, 1'b0}); end
    end
    step();
    vecs++;
    if ({count, busy, done, irq} !== {4'd3, 1'b0, 1'b1, 1'b1})
      begin errs++; $display("FAIL oneshot_tc: got %h want %h", {count, busy, done, irq}, {4'd3, 1'b0, 1'b1, 1'b1}); end
    step();
    vecs++;
    if ({count, busy, done, irq} !== {4'd3, 1'b0, 1'b0, 1'b1})
      begin errs++; $display("FAIL oneshot_hold: got %h want %h", {count, busy, done, irq}, {4'd3, 1'b0, 1'b0, 1'b1}); end
    irq_clr = 1'b1;
    step();
    irq_clr = 1'b0;
    vecs++;
    if (irq !== 1'b0)
      begin errs++; $display("FAIL oneshot_irq_clr: got %b want 0", irq); end
  endtask

  task automatic test_periodic();
    launch(4'd2, MODE_PERIODIC);
    for (int k = 1; k <= 7; k++) begin
      step();
      vecs++;
      if ({count, busy, done} !== {4'(k % 3), 1'b1, (k % 3) == 0})
        begin errs++; $display("FAIL periodic_k%0d: got %h want %h", k, {count, busy, done}, {4'(k % 3), 1'b1, (k % 3) == 0}); end
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    vecs++;
    if ({count, busy, done, irq} !== {4'd0, 1'b0, 1'b0, 1'b1})
      begin errs++; $display("FAIL periodic_stop: got %h want %h", {count, busy, done, irq}, {4'd0, 1'b0, 1'b0, 1'b1}); end
    irq_clr = 1'b1;
    step();
    irq_clr = 1'b0;
  endtask

  task automatic test_pause();
    int exp_cnt[11] = '{1, 1, 1, 1, 1, 1, 2, 3, 4, 5, 5};
    launch(4'd5, MODE_ONESHOT);
    for (int k = 1; k <= 11; k++) begin
      pause = (k >= 2 && k <= 5);
      step();
      vecs++;
      if ({count, busy, done} !== {4'(exp_cnt[k-1]), k != 11, k == 11})
        begin errs++; $display("FAIL pause_k%0d: got %h want %h", k, {count, busy, done}, {4'(exp_cnt[k-1]), k != 11, k == 11}); end
      if (k == 3) begin
        vecs++;
        if (dbg_state !== ST_PAUSE)
          begin errs++; $display("FAIL pause_state: got %0d want %0d", dbg_state, ST_PAUSE); end
      end
    end
    pause   = 1'b0;
    irq_clr = 1'b1;
    step();
    irq_clr = 1'b0;
  endtask

  task automatic test_stop_at_tc();
    launch(4'd2, MODE_ONESHOT);
    step();
    step();
    stop = 1'b1;  // count==TC at this edge
    step();
    stop = 1'b0;
    vecs++;
    if ({count, busy, done, irq, dbg_state} !== {4'd0, 1'b0, 1'b0, 1'b0, ST_IDLE})
      begin errs++; $display("FAIL stop_at_tc: got %h want %h", {count, busy, done, irq, dbg_state}, {4'd0, 1'b0, 1'b0, 1'b0, ST_IDLE}); end
    step();
    vecs++;
    if ({done, irq} !== 2'b00)
      begin errs++; $display("FAIL stop_no_done: got %b want 00", {done, irq}); end
  endtask

  task automatic test_tc_zero();
    launch(4'd0, MODE_ONESHOT);
    vecs++;
    if ({count, busy, done} !== {4'd0, 1'b1, 1'b0})
      begin errs++; $display("FAIL tc0_start: got %h want %h", {count, busy, done}, {4'd0, 1'b1, 1'b0}); end
    irq_clr = 1'b1;
    step();
    irq_clr = 1'b0;
    vecs++;
    if ({count, busy, done, irq} !== {4'd0, 1'b0, 1'b1, 1'b1})
      begin errs++; $display("FAIL tc0_done_irq: got %h want %h", {count, busy, done, irq}, {4'd0, 1'b0, 1'b1, 1'b1}); end
    irq_clr = 1'b1;
    step();
    irq_clr = 1'b0;
  endtask

  task automatic test_start_while_busy();
    launch(4'd3, MODE_PERIODIC);
    start    = 1'b1;  // held high and new parameters offered; all ignored
    load_val = 4'd1;
    mode     = MODE_ONESHOT;
    for (int k = 1; k <= 5; k++) begin
      step();
      vecs++;
      if ({count, busy, done} !== {4'(k % 4), 1'b1, k == 4})
        begin errs++; $display("FAIL busy_start_k%0d: got %h want %h", k, {count, busy, done}, {4'(k % 4), 1'b1, k == 4}); end
    end
    start = 1'b0;
    stop  = 1'b1;
    step();
    stop  = 1'b0;
    irq_clr = 1'b1;
    step();
    irq_clr = 1'b0;
  endtask

  task automatic test_reset_midrun();
    launch(4'd3, MODE_PERIODIC);
    step();
    step();
    step();  // count 3, done pulses at the next edge
    #2;
    reset = 1'b1;
    #1;
    vecs++;
    if ({count, busy, done, irq, dbg_state} !== '0)
      begin errs++; $display("FAIL reset_midrun: got %h want 0", {count, busy, done, irq, dbg_state}); end
    #1;
    reset = 1'b0;
    step();
    vecs++;
    if ({count, busy, done, irq} !== '0)
      begin errs++; $display("FAIL reset_after: got %h want 0", {count, busy, done, irq}); end
  endtask

`ifdef TIMER_CTRL_PRESCALE_EN
  task automatic test_prescale();
    presc = 8'd3;
    launch(4'd1, MODE_ONESHOT);
    for (int k = 1; k <= 8; k++) begin
      step();
      vecs++;
      if ({count, busy, done} !== {(k < 4) ? 4'd0 : 4'd1, k != 8, k == 8})
        begin errs++; $display("FAIL presc_k%0d: got %h want %h", k, {count, busy, done}, {(k < 4) ? 4'd0 : 4'd1, k != 8, k == 8}); end
    end
    presc   = 8'd0;
    irq_clr = 1'b1;
    step();
    irq_clr = 1'b0;
  endtask
`endif

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    stop     = 1'b0;
    pause    = 1'b0;
    mode     = 1'b0;
    irq_clr  = 1'b0;
    load_val = '0;
    presc    = '0;
    test_reset();
    test_oneshot();
    test_periodic();
    test_pause();
    test_stop_at_tc();
    test_tc_zero();
    test_start_while_busy();
    test_reset_midrun();
`ifdef TIMER_CTRL_PRESCALE_EN
    test_prescale();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
